// File: rtl/cobra_io_pkg.sv
// Shared types for the Cobra1 I/O pin conditioning path.
package cobra_io_pkg;

  typedef enum logic [1:0] {EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH} edge_sel_t;

  typedef enum logic [1:0] {PQ_IDLE, PQ_ARMED, PQ_HOLD} pq_state_t;

  localparam int DROP_CNT_W = 8;

  // True when a level transition in direction `rise` is selected by `sel`.
  function automatic logic edge_match(input edge_sel_t sel, input logic rise);
    return (sel == EDGE_BOTH) || (rise ? (sel == EDGE_RISE) : (sel == EDGE_FALL));
  endfunction

endpackage

// File: rtl/sync_filter.sv
// Pin synchroniser plus glitch filter; level_changed is high in the cycle
// before the clock edge at which level flips.
module sync_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 16,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic level_changed
);
  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sync_out;

  assign sync_out      = sync_q[SYNC_STAGES-1];
  // Counter already holds FILTER_LEN differing samples: flip on this edge.
  assign level_changed = (cnt_q == CNT_W'(FILTER_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      level  <= IDLE_LEVEL;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (level_changed) begin
        level <= ~level;
        cnt_q <= '0;
      end else if (sync_out == level) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pulse_qualifier.sv
// Turns an asynchronous pin into single-cycle trigger pulses with edge
// selection and a post-trigger hold-off window.
module pulse_qualifier
  import cobra_io_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 16,
  parameter int   HOLDOFF     = 1024,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  din,
  input  logic                  enable,
  input  logic [1:0]            edge_sel,
  output logic                  trigger,
  output logic                  level,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  pq_state_t   state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic level_changed, match;
  logic trig_d, drop_d, busy_d;

  sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN),
    .IDLE_LEVEL  (IDLE_LEVEL)
  ) u_filter (
    .clk           (clk),
    .rst_n         (rst_n),
    .din           (din),
    .level         (level),
    .level_changed (level_changed)
  );

  // Direction of the pending flip is the inverse of the current level.
  assign match = level_changed && edge_match(edge_sel_t'(edge_sel), ~level);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PQ_IDLE;
      hold_q   <= '0;
      trigger  <= 1'b0;
      busy     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      trigger <= trig_d;
      busy    <= busy_d;
      if (drop_d && (drop_cnt != {DROP_CNT_W{1'b1}}))
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (!enable) begin
      state_d = PQ_IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        PQ_IDLE:  state_d = PQ_ARMED;
        PQ_ARMED: if (match && (HOLDOFF != 0)) begin
          state_d = PQ_HOLD;
          hold_d  = HOLD_W'(HOLDOFF);
        end
        PQ_HOLD: begin
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q == HOLD_W'(1)) state_d = PQ_ARMED;
        end
        default: state_d = PQ_IDLE;
      endcase
    end
  end

  // An edge landing in the last HOLD cycle is still a drop, not a trigger.
  always_comb begin
    trig_d = (state_q == PQ_ARMED) && match;
    drop_d = (state_q == PQ_HOLD) && match;
    busy_d = (state_q == PQ_HOLD) && enable;
  end

endmodule

// File: tb/tb_pulse_qualifier.sv
// Randomised bench for pulse_qualifier against a sample-history reference model.
module tb_pulse_qualifier;
  localparam int S = 2;
  localparam int F = 4;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       enable;
  logic [1:0] edge_sel;
  logic       trigger, level, busy;
  logic [7:0] drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  pulse_qualifier #(
    .SYNC_STAGES (S),
    .FILTER_LEN  (F),
    .HOLDOFF     (H),
    .IDLE_LEVEL  (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .enable   (enable),
    .edge_sel (edge_sel),
    .trigger  (trigger),
    .level    (level),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: edge-indexed din history; level flips once the F
  // synchronised samples since the last flip all disagree with it.
  int din_at[$];
  int t, last_flip;
  int m_level, m_mode, m_hold_left, m_trig, m_busy, m_drop;
  localparam int M_IDLE = 0, M_ARMED = 1, M_HOLD = 2;

  function automatic int sync_at(int e);
    return (e >= S) ? din_at[e - S] : 1;
  endfunction

  task automatic model_reset();
    din_at.delete();
    t = 0; last_flip = -1;
    m_level = 1; m_mode = M_IDLE; m_hold_left = 0;
    m_trig = 0; m_busy = 0; m_drop = 0;
  endtask

  task automatic model_step();
    bit flip, rise, sel_ok;
    din_at.push_back(int'(din));
    flip = (t - F > last_flip);
    for (int k = 1; k <= F; k++)
      if (sync_at(t - k) == m_level) flip = 0;
    rise   = (m_level == 0);
    sel_ok = flip && (rise ? edge_sel[0] : edge_sel[1]);
    m_trig = (m_mode == M_ARMED) && sel_ok;
    m_busy = (m_mode == M_HOLD) && enable;
    if (m_mode == M_HOLD && sel_ok && m_drop < 255) m_drop++;
    if (!enable) begin
      m_mode = M_IDLE; m_hold_left = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_ARMED;
    end else if (m_mode == M_ARMED) begin
      if (sel_ok) begin m_mode = M_HOLD; m_hold_left = H; end
    end else begin
      if (m_hold_left == 1) m_mode = M_ARMED;
      m_hold_left--;
    end
    if (flip) begin m_level ^= 1; last_flip = t; end
    t++;
  endtask

  task automatic compare_all();
    chk("trigger", int'(trigger), m_trig);
    chk("level", int'(level), m_level);
    chk("busy", int'(busy), m_busy);
    chk("drop_cnt", int'(drop_cnt), m_drop);
  endtask

  int run_len, en_len, trig_seen, drop_seen;

  initial begin
    rst_n = 1'b0; din = 1'b1; enable = 1'b0; edge_sel = 2'b10;
    trig_seen = 0; drop_seen = 0;
    model_reset();
    run_len = 20; en_len = 0;
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    enable = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      compare_all();
      if (trigger) trig_seen++;
      if (drop_cnt != 0) drop_seen++;

      if (cyc == 2000) begin
        #2 rst_n = 1'b0; din = ~din;
        model_reset();
        #1;
        chk("rst_trigger", int'(trigger), 0);
        chk("rst_level", int'(level), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        din = 1'b1; run_len = 15;
      end
      if (cyc == 2003) rst_n = 1'b1;

      // pin: mix of sub-filter glitches, hold-off-range gaps and long runs
      if (run_len == 0) begin
        din = ~din;
        case ($urandom_range(0, 3))
          0: run_len = $urandom_range(1, 5);
          1: run_len = $urandom_range(4, 10);
          default: run_len = $urandom_range(10, 40);
        endcase
      end else run_len--;

      if (en_len > 0) begin
        en_len--;
        if (en_len == 0) enable = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        enable = 1'b0; en_len = $urandom_range(1, 30);
      end
      if ($urandom_range(0, 99) == 0) edge_sel = 2'($urandom_range(0, 3));
    end

    chk("triggers_seen", int'(trig_seen > 0), 1);
    chk("drops_seen", int'(drop_seen > 0), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
